pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Sequencing controller in front of the 16-bit PWM counter/comparator. It accepts period/duty/direction configurations over a valid/ready handshake and drives the PWM's ARR, CCR and dir inputs plus a run enable. Duty (CCR) is ramped toward a target in fixed steps, one step per PWM period (soft start, soft change, soft stop). All register changes to a running PWM land only on period boundaries, so the wave never glitches.

Parameters:
W, 16, width of ARR/CCR/step datapath (matches PWM counter width).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration request
cfg_ready  out  1  controller can accept a configuration
cfg_arr  in  W  requested period (auto-reload) value
cfg_ccr  in  W  requested target duty compare value
cfg_step  in  W  CCR increment/decrement per period; 0 = jump directly
cfg_dir  in  1  count direction passed to PWM (1 = up, 0 = down)
stop  in  1  level/pulse request: ramp duty to 0, then disable PWM
period_end  in  1  one-cycle strobe from PWM at counter wrap (c==ARR up / c==0 down)
pwm_arr  out  W  ARR driven to PWM
pwm_ccr  out  W  CCR driven to PWM
pwm_dir  out  1  dir driven to PWM
pwm_en  out  1  PWM run enable; PWM held in reset while 0
busy  out  1  state != IDLE
at_target  out  1  high in HOLD (pwm_ccr == target)
done  out  1  one-cycle pulse when the stop sequence completes

Behaviour:
- Reset (async, rst_n=0): state IDLE; pwm_arr=0, pwm_ccr=0, pwm_dir=0, pwm_en=0, done=0, busy=0, at_target=0, cfg_ready=1. All internal target/step/pending registers cleared. Asserting rst_n low mid-ramp drops pwm_en immediately. No sequence resumes after reset.
- A handshake occurs on a clk edge where cfg_valid && cfg_ready. Target tgt = min(cfg_ccr, cfg_arr). step is latched.
- cfg_ready = 1 in IDLE and in HOLD with no stop pending; 0 otherwise (combinational from state).
- stop is sampled each cycle. It is ignored in IDLE. Otherwise it sets stop_pend and tgt=0. Stop has priority over a same-cycle cfg_valid, and that cfg is not accepted because cfg_ready drops the same cycle stop is seen.
- States:
  - IDLE: on handshake, next cycle pwm_arr=cfg_arr, pwm_dir=cfg_dir, pwm_ccr=0, pwm_en=1; go RAMP.
  - RAMP: on each period_end, pwm_ccr moves one step toward tgt. Up: sum computed W+1 bits, and if pwm_ccr+step >= tgt then pwm_ccr=tgt. Down: if pwm_ccr < tgt+step (no underflow) then pwm_ccr=tgt. step=0 means pwm_ccr=tgt. When pwm_ccr reaches tgt: go STOPW if stop_pend, else HOLD.
  - HOLD: outputs steady. On handshake, latch new tgt/step, record arr_pend=cfg_arr and dir_pend=cfg_dir, go RAMP. Pending arr/dir apply at the next period_end, in the same cycle as the first step. If pwm_ccr exceeds the new ARR at that boundary, pwm_ccr is first clamped to the new ARR, then stepping continues from there.
  - STOPW: wait for the next period_end, then pwm_en=0, pwm_ccr=0, clear stop_pend, done=1 for one cycle, go IDLE. pwm_arr and pwm_dir keep their last values.
- Between period_end strobes in RAMP, pwm_ccr is constant. period_end in IDLE is ignored.
- If tgt == pwm_ccr at acceptance in HOLD, RAMP exits on the first period_end.
- Latency: acceptance to pwm_en=1 is 1 cycle. Each ramp step takes effect 1 cycle after its period_end.

Test Plan:
- Soft start: cfg arr=9, ccr=6, step=2, dir=1; period_end every 10 clks -> pwm_en=1 one cycle after handshake; pwm_ccr sequence 0,2,4,6; at_target=1 after 3rd period_end; cfg_ready=0 during RAMP.
- Saturation/jump: cfg ccr=7, step=5 -> pwm_ccr 0,5,7. Then in HOLD cfg ccr=2, step=0 -> pwm_ccr=2 at next period_end. cfg_ccr=20 with arr=9 -> tgt clamped to 9.
- ARR shrink in HOLD: running arr=99, ccr=80; cfg arr=49, ccr=30, step=10 -> at next period_end pwm_arr=49, pwm_ccr clamped to 49 then stepped to 39; next period_end pwm_ccr=30.
- Stop: from HOLD ccr=6, step=2, assert stop together with cfg_valid -> cfg not accepted; pwm_ccr 4,2,0; one more period_end later pwm_en=0, done pulses once, busy=0, cfg_ready=1.
- Reset mid-ramp: drop rst_n between clk edges during RAMP -> pwm_en, pwm_ccr, pwm_arr are 0 immediately; after release, state IDLE, cfg_ready=1, no further ramp steps on period_end.
- Down-count handoff: cfg dir=0, arr=15, ccr=8, step=8 -> pwm_dir=0; ramp 0,8; a later cfg with dir=1 applies pwm_dir=1 only at the next period_end.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Sequencer in front of the PWM counter: ramps CCR toward a target one step
// per period and only touches ARR/CCR/dir on period boundaries.
module pwm_ramp_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_arr,
    input  logic [W-1:0] cfg_ccr,
    input  logic [W-1:0] cfg_step,
    input  logic         cfg_dir,
    input  logic         stop,
    input  logic         period_end,
    output logic [W-1:0] pwm_arr,
    output logic [W-1:0] pwm_ccr,
    output logic         pwm_dir,
    output logic         pwm_en,
    output logic         busy,
    output logic         at_target,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        HOLD,
        STOPW
    } state_t;

    state_t state;

    logic [W-1:0] tgt;
    logic [W-1:0] step;
    logic [W-1:0] arr_pend;
    logic         dir_pend;
    logic         pend_vld;
    logic         stop_pend;

    logic         hs;
    logic         stop_req;
    logic         stop_eff;
    logic [W-1:0] tgt_eff;
    logic [W-1:0] cfg_tgt;
    logic [W-1:0] base;
    logic [W-1:0] nxt;
    logic [W:0]   sum;
    logic [W:0]   lim;

    assign stop_req  = stop && (state != IDLE);
    assign stop_eff  = stop_pend || stop_req;
    assign cfg_ready = (state == IDLE) ||
                       ((state == HOLD) && !stop_pend && !stop);
    assign hs        = cfg_valid && cfg_ready;
    assign busy      = (state != IDLE);
    assign at_target = (state == HOLD);
    assign cfg_tgt   = (cfg_ccr < cfg_arr) ? cfg_ccr : cfg_arr;
    // A stop seen this cycle retargets the step already being computed.
    assign tgt_eff   = stop_req ? '0 : tgt;

    always_comb begin
        base = pwm_ccr;
        nxt  = tgt_eff;
        if (pend_vld && (pwm_ccr > arr_pend))
            base = arr_pend;
        sum = {1'b0, base} + {1'b0, step};
        lim = {1'b0, tgt_eff} + {1'b0, step};
        if (step == '0) begin
            nxt = tgt_eff;
        end else if (base < tgt_eff) begin
            nxt = (sum >= {1'b0, tgt_eff}) ? tgt_eff : sum[W-1:0];
        end else if (base > tgt_eff) begin
            nxt = ({1'b0, base} < lim) ? tgt_eff : (base - step);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pwm_arr   <= '0;
            pwm_ccr   <= '0;
            pwm_dir   <= 1'b0;
            pwm_en    <= 1'b0;
            done      <= 1'b0;
            tgt       <= '0;
            step      <= '0;
            arr_pend  <= '0;
            dir_pend  <= 1'b0;
            pend_vld  <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop_req) begin
                stop_pend <= 1'b1;
                tgt       <= '0;
            end
            case (state)
                IDLE: begin
                    if (hs) begin
                        pwm_arr <= cfg_arr;
                        pwm_dir <= cfg_dir;
                        pwm_ccr <= '0;
                        pwm_en  <= 1'b1;
                        tgt     <= cfg_tgt;
                        step    <= cfg_step;
                        state   <= RAMP;
                    end
                end
                RAMP: begin
                    if (period_end) begin
                        if (pend_vld) begin
                            pwm_arr  <= arr_pend;
                            pwm_dir  <= dir_pend;
                            pend_vld <= 1'b0;
                        end
                        pwm_ccr <= nxt;
                        if (nxt == tgt_eff)
                            state <= stop_eff ? STOPW : HOLD;
                    end
                end
                HOLD: begin
                    if (stop_req) begin
                        state <= RAMP;
                    end else if (hs) begin
                        tgt      <= cfg_tgt;
                        step     <= cfg_step;
                        arr_pend <= cfg_arr;
                        dir_pend <= cfg_dir;
                        pend_vld <= 1'b1;
                        state    <= RAMP;
                    end
                end
                STOPW: begin
                    if (period_end) begin
                        pwm_en    <= 1'b0;
                        pwm_ccr   <= '0;
                        stop_pend <= 1'b0;
                        pend_vld  <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: soft start, saturation, ARR shrink,
// stop sequence, direction handoff and asynchronous reset mid-ramp.
module tb_pwm_ramp_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_arr;
    logic [W-1:0] cfg_ccr;
    logic [W-1:0] cfg_step;
    logic         cfg_dir;
    logic         stop;
    logic         period_end;
    logic [W-1:0] pwm_arr;
    logic [W-1:0] pwm_ccr;
    logic         pwm_dir;
    logic         pwm_en;
    logic         busy;
    logic         at_target;
    logic         done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_arr    (cfg_arr),
        .cfg_ccr    (cfg_ccr),
        .cfg_step   (cfg_step),
        .cfg_dir    (cfg_dir),
        .stop       (stop),
        .period_end (period_end),
        .pwm_arr    (pwm_arr),
        .pwm_ccr    (pwm_ccr),
        .pwm_dir    (pwm_dir),
        .pwm_en     (pwm_en),
        .busy       (busy),
        .at_target  (at_target),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One period_end strobe; returns at the negedge after it took effect.
    task automatic pe(input int gap);
        idle(gap);
        period_end = 1'b1;
        @(negedge clk);
        period_end = 1'b0;
    endtask

    task automatic cfg(input int arr, input int ccr, input int stp,
                       input logic dir);
        cfg_valid = 1'b1;
        cfg_arr   = W'(arr);
        cfg_ccr   = W'(ccr);
        cfg_step  = W'(stp);
        cfg_dir   = dir;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_arr    = '0;
        cfg_ccr    = '0;
        cfg_step   = '0;
        cfg_dir    = 1'b0;
        stop       = 1'b0;
        period_end = 1'b0;
        idle(3);
        check("rst_en", pwm_en, 0);
        check("rst_ccr", pwm_ccr, 0);
        check("rst_arr", pwm_arr, 0);
        check("rst_dir", pwm_dir, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_at", at_target, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        idle(2);

        // Soft start: 0,2,4,6
        cfg(9, 6, 2, 1'b1);
        check("ss_en", pwm_en, 1);
        check("ss_arr", pwm_arr, 9);
        check("ss_dir", pwm_dir, 1);
        check("ss_ccr0", pwm_ccr, 0);
        check("ss_ready", cfg_ready, 0);
        check("ss_busy", busy, 1);
        idle(4);
        check("ss_flat", pwm_ccr, 0);
        pe(5);
        check("ss_ccr2", pwm_ccr, 2);
        check("ss_at2", at_target, 0);
        pe(9);
        check("ss_ccr4", pwm_ccr, 4);
        pe(9);
        check("ss_ccr6", pwm_ccr, 6);
        check("ss_at6", at_target, 1);
        check("ss_rdy6", cfg_ready, 1);

        // Stop with a same-cycle cfg: cfg is dropped, ramp down 4,2,0
        stop      = 1'b1;
        cfg_valid = 1'b1;
        cfg_arr   = 9;
        cfg_ccr   = 9;
        cfg_step  = 1;
        #1;
        check("st_ready", cfg_ready, 0);
        @(negedge clk);
        stop      = 1'b0;
        cfg_valid = 1'b0;
        check("st_busy", busy, 1);
        check("st_at", at_target, 0);
        pe(3);
        check("st_ccr4", pwm_ccr, 4);
        pe(3);
        check("st_ccr2", pwm_ccr, 2);
        pe(3);
        check("st_ccr0", pwm_ccr, 0);
        check("st_en0", pwm_en, 1);
        check("st_done0", done, 0);
        pe(3);
        check("st_en", pwm_en, 0);
        check("st_done", done, 1);
        check("st_idle", busy, 0);
        check("st_rdy", cfg_ready, 1);
        check("st_arr", pwm_arr, 9);
        idle(1);
        check("st_done1", done, 0);
        pe(2);
        check("idle_pe_en", pwm_en, 0);
        check("idle_pe_ccr", pwm_ccr, 0);

        // Saturation and jump
        cfg(9, 7, 5, 1'b1);
        pe(3);
        check("sat_ccr5", pwm_ccr, 5);
        pe(3);
        check("sat_ccr7", pwm_ccr, 7);
        check("sat_at", at_target, 1);
        cfg(9, 2, 0, 1'b1);
        check("jmp_at0", at_target, 0);
        check("jmp_hold", pwm_ccr, 7);
        pe(3);
        check("jmp_ccr", pwm_ccr, 2);
        check("jmp_at", at_target, 1);
        cfg(9, 20, 3, 1'b1);
        pe(3);
        check("clp_ccr5", pwm_ccr, 5);
        pe(3);
        check("clp_ccr8", pwm_ccr, 8);
        pe(3);
        check("clp_ccr9", pwm_ccr, 9);
        check("clp_at", at_target, 1);

        // ARR shrink while holding
        cfg(99, 80, 0, 1'b1);
        check("grow_arr_wait", pwm_arr, 9);
        pe(3);
        check("grow_arr", pwm_arr, 99);
        check("grow_ccr", pwm_ccr, 80);
        cfg(49, 30, 10, 1'b1);
        check("shr_arr_wait", pwm_arr, 99);
        pe(3);
        check("shr_arr", pwm_arr, 49);
        check("shr_ccr39", pwm_ccr, 39);
        pe(3);
        check("shr_ccr30", pwm_ccr, 30);
        check("shr_at", at_target, 1);

        // Stop from 30, step 10
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        pe(2);
        check("st2_ccr20", pwm_ccr, 20);
        pe(2);
        pe(2);
        check("st2_ccr0", pwm_ccr, 0);
        pe(2);
        check("st2_done", done, 1);
        check("st2_en", pwm_en, 0);

        // Down-count start and direction handoff
        cfg(15, 8, 8, 1'b0);
        check("dn_dir", pwm_dir, 0);
        check("dn_arr", pwm_arr, 15);
        pe(3);
        check("dn_ccr8", pwm_ccr, 8);
        check("dn_at", at_target, 1);
        cfg(15, 8, 8, 1'b1);
        check("dn_dir_wait", pwm_dir, 0);
        pe(3);
        check("dn_dir_up", pwm_dir, 1);
        check("dn_ccr_same", pwm_ccr, 8);
        check("dn_at2", at_target, 1);

        // Asynchronous reset between edges during a ramp
        cfg(15, 12, 2, 1'b1);
        pe(2);
        check("rr_ccr10", pwm_ccr, 10);
        #2 rst_n = 1'b0;
        #1;
        check("rr_en", pwm_en, 0);
        check("rr_ccr", pwm_ccr, 0);
        check("rr_arr", pwm_arr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("rr_ready", cfg_ready, 1);
        check("rr_busy", busy, 0);
        pe(2);
        check("rr_pe_ccr", pwm_ccr, 0);
        check("rr_pe_en", pwm_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
